// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the UART receiver family
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK_WAIT
    } rx_state_t;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// rtl/uart_os_tick_gen.sv - free-running oversample tick from a fractional accumulator
module uart_os_tick_gen #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [32:0] INC = 33'(BAUD * OVERSAMPLE);
    localparam logic [32:0] MOD = 33'(CLK_FREQ);

    logic [32:0] acc;
    logic [32:0] sum;

    // The remainder carries over, so the long-run tick rate is exact.
    assign sum = acc + INC;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= MOD) begin
            acc  <= sum - MOD;
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with voting, error flags and valid/ready output
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int IDLE_BITS  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 rx_idle
);

    localparam int PW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS);
    localparam int IW = clog2(IDLE_BITS + 1);
    localparam logic [PW-1:0] CENTRE    = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PHASE_END = PW'(OVERSAMPLE - 1);
    localparam logic [PW:0]   BRK_LAST  = (PW + 1)'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_BITS);

    logic                 tick;
    logic                 sync1, sync2, line_prev;
    logic [2:0]           samp;
    logic                 vote, fall, centre, last_stop, done;
    logic                 char_frame, char_break;
    rx_state_t            state;
    logic [PW-1:0]        phase;
    logic [PW:0]          high_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, par_bad, stop_bad, any_one;
    logic [PW-1:0]        idle_phase;
    logic [IW-1:0]        idle_cnt;

    uart_os_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign vote       = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign fall       = line_prev & ~sync2;
    assign centre     = tick && (phase == CENTRE);
    assign last_stop  = (state == ST_STOP2) || (state == ST_STOP1 && STOP_BITS == 1);
    assign done       = centre && last_stop;
    // Include the vote being taken right now: it is the last stop bit.
    assign char_frame = stop_bad | ~vote;
    assign char_break = ~(any_one | vote);
    assign rx_idle    = (idle_cnt == IDLE_SAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            samp      <= 3'b111;
        end else begin
            sync1     <= rxd;
            sync2     <= sync1;
            line_prev <= sync2;
            if (tick) samp <= {samp[1:0], sync2};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            phase    <= '0;
            high_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            any_one  <= 1'b0;
        end else begin
            if (tick) phase <= phase + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state <= ST_START;
                        phase <= '0;
                    end
                end
                ST_START: begin
                    if (centre) begin
                        if (vote) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DATA;
                            bit_cnt  <= '0;
                            par_acc  <= 1'b0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                            any_one  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (centre) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ vote;
                        any_one <= any_one | vote;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST)
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    if (centre) begin
                        any_one <= any_one | vote;
                        par_bad <= (PARITY == PAR_ODD) ? ~(par_acc ^ vote) : (par_acc ^ vote);
                        state   <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (centre) begin
                        if (STOP_BITS == 2) begin
                            stop_bad <= ~vote;
                            any_one  <= any_one | vote;
                            state    <= ST_STOP2;
                        end else begin
                            state <= char_break ? ST_BREAK_WAIT : ST_IDLE;
                        end
                    end
                end
                ST_STOP2: begin
                    if (centre) state <= char_break ? ST_BREAK_WAIT : ST_IDLE;
                end
                ST_BREAK_WAIT: begin
                    // Any low tick restarts the count of consecutive high ticks.
                    if (tick) begin
                        if (!sync2) begin
                            high_cnt <= '0;
                        end else if (high_cnt == BRK_LAST) begin
                            high_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            high_cnt <= high_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
            idle_phase <= '0;
            idle_cnt   <= '0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    frame_err  <= char_frame;
                    parity_err <= par_bad;
                    break_det  <= char_break;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (state != ST_IDLE || !sync2) begin
                idle_phase <= '0;
                idle_cnt   <= '0;
            end else if (tick) begin
                idle_phase <= idle_phase + 1'b1;
                if (idle_phase == PHASE_END && idle_cnt != IDLE_SAT)
                    idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and the next generation of the team's 8N1 receiver. It supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. It adds majority-vote sampling, false-start rejection, framing/parity/break/overrun detection and a valid/ready output handshake. It sits between the serial RxD pin and the image-data ingest logic.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, oversampling ticks per bit; power of 2, 8..32
DATA_BITS, 8, data bits per character, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
IDLE_BITS, 20, bit periods of continuous line-high before rx_idle asserts

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
rxd  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  received character, LSB = first bit on the line
rx_valid  out  1  rx_data and the status flags hold an unconsumed character
rx_ready  in  1  consumer accepts; a transfer occurs when rx_valid && rx_ready
frame_err  out  1  stop bit(s) sampled low; qualified by rx_valid
parity_err  out  1  parity mismatch; qualified by rx_valid; 0 when PARITY=0
break_det  out  1  character was a line break; qualified by rx_valid
overrun  out  1  one-cycle pulse: a character completed while the holding register was full
rx_idle  out  1  line idle for IDLE_BITS bit periods

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchroniser and vote registers preset to 1, tick counters cleared. Reset mid-character abandons it without setting any flag.
- Input path: 2-flop synchroniser on every clk. The synchronised line is shifted into a 3-deep sample register on each oversample tick. The bit value is the majority of the last 3 samples.
- Tick: an enable pulse every CLK_FREQ/(BAUD*OVERSAMPLE) clocks, using an accumulator with fractional error. It free-runs. The bit-phase counter (log2(OVERSAMPLE) bits) is cleared on start-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE: a synchronised falling edge moves to START and clears the phase counter.
- START: at phase OVERSAMPLE/2-1 the vote is taken. If the vote is 1, this is a false start and the FSM returns to IDLE with no flags. Otherwise the FSM goes to DATA and the bit counter is set to 0.
- DATA/PARITY/STOP: every OVERSAMPLE ticks after the start centre, the vote is taken at the bit centre.
  - DATA shifts in LSB-first until DATA_BITS bits have been taken.
  - PARITY exists only if PARITY≠0. Odd parity expects XOR(data, p) = 1; even parity expects 0.
  - STOP1 is followed by STOP2 only if STOP_BITS=2.
- Completion at the centre of the last stop bit:
  - frame_err = any stop bit sampled 0.
  - break_det = all data bits, the parity bit (if present) and the stop bit(s) are 0; frame_err is also 1 in this case.
  - After a break the FSM goes to BREAK_WAIT and returns to IDLE only after OVERSAMPLE consecutive ticks of line high. Otherwise it returns directly to IDLE at the stop-bit centre; there is no wait for the end of the stop bit.
- Holding register:
  - At completion, if rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle, rx_data and the flags load and rx_valid=1 on the next cycle.
  - If rx_valid=1 and rx_ready=0, the new character is dropped, the held character and flags are unchanged, and overrun pulses 1 cycle.
  - rx_valid clears the cycle after a transfer unless a load happens in that same cycle.
  - Flags are held stable while rx_valid=1.
- rx_idle: a counter of bit periods runs while the FSM is IDLE and the line is high, saturating at IDLE_BITS. rx_idle = (count == IDLE_BITS). A falling edge clears it in the same cycle that START is entered.
- Latency: rx_valid rises 1 clk after the tick at the last stop-bit centre.

Decomposition:
- Shared package uart_pkg holds:
  - localparams for the parity encodings (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2);
  - the FSM state encoding;
  - a log2 constant function.
- Sub-module uart_os_tick_gen(CLK_FREQ, BAUD, OVERSAMPLE) produces the oversample tick and is reusable by a future transmitter. Everything else stays in one module.

Test Plan:
All directed tests use CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 (1 tick/clk, 16 clk/bit).
- 8N1, send 0xA5 then 0x3C with rx_ready=1 -> two transfers of 0xA5 and 0x3C with all flags 0; rx_valid rises 1 clk after each stop-bit centre.
- PARITY=2, DATA_BITS=7, send 0x41 with parity bit 1 -> rx_data=0x41, parity_err=1, frame_err=0. Resend with parity bit 0 -> parity_err=0.
- STOP_BITS=2, second stop bit driven 0 -> frame_err=1, break_det=0, rx_data correct.
- Line held 0 for 30 bit periods, then 1 -> a single character with rx_data=0, break_det=1, frame_err=1. No further characters until the line has been high 16 clk.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses exactly 1 clk at the 0x22 stop centre. Raise rx_ready -> 0x11 transfers and rx_valid drops.
- 5-clk low glitch on idle line -> no rx_valid, FSM back to IDLE. rx_idle asserts at 320 clk of line-high and drops on the next real start edge. Reset asserted mid-byte -> no output and clean reception of the next byte.
